// File: rtl/matrix_add_stream.sv
// rtl/matrix_add_stream.sv - element-serial signed-magnitude matrix add/sub, P lanes per beat
// Valid/ready in and out, one-deep registered output, per-lane saturation.
module matrix_add_stream #(
  parameter int N = 32,
  parameter int R = 6,
  parameter int C = 6,
  parameter int P = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [P*N-1:0] a_in,
  input  logic [P*N-1:0] b_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P*N-1:0] c_out,
  output logic           out_last,
  output logic           sat_flag,
  output logic           busy,
  output logic           done
);

  localparam int BEATS = R * C / P;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  generate
    if ((R * C) % P != 0) begin : g_bad_lanes
      $error("matrix_add_stream: R*C must be a multiple of P");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mode_q, mode_d;
  logic           out_valid_q, out_valid_d;
  logic [P*N-1:0] c_q, c_d;
  logic           last_q, last_d;
  logic           sat_q, sat_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           in_xfer;
  logic           op_sub;
  logic           at_last;
  logic [P*N-1:0] lane_res;
  logic [P-1:0]   lane_sat;

  // Returns {saturated, sign, magnitude}; a zero magnitude always comes out as +0.
  function automatic logic [N:0] lane_op(input logic [N-1:0] a,
                                         input logic [N-1:0] b,
                                         input logic         sub);
    logic          sa, sb, sr, sat;
    logic [N-2:0]  am, bm, mag;
    logic [N-1:0]  sum;
    sa  = a[N-1];
    sb  = b[N-1] ^ sub;
    am  = a[N-2:0];
    bm  = b[N-2:0];
    sat = 1'b0;
    sum = {1'b0, am} + {1'b0, bm};
    if (sa == sb) begin
      sr = sa;
      if (sum[N-1]) begin
        mag = '1;
        sat = 1'b1;
      end else begin
        mag = sum[N-2:0];
      end
    end else if (am >= bm) begin
      sr  = sa;
      mag = am - bm;
    end else begin
      sr  = sb;
      mag = bm - am;
    end
    if (mag == '0) sr = 1'b0;
    return {sat, sr, mag};
  endfunction

  assign in_ready = !out_valid_q | out_ready;
  assign in_xfer  = in_valid & in_ready;
  assign at_last  = (cnt_q == LAST_CNT);
  // The first beat of a matrix uses the live mode; later beats use the latched copy.
  assign op_sub   = (state_q == S_IDLE) ? mode : mode_q;

  always_comb begin
    lane_res = '0;
    lane_sat = '0;
    for (int k = 0; k < P; k++) begin
      {lane_sat[k], lane_res[k*N +: N]} = lane_op(a_in[k*N +: N], b_in[k*N +: N], op_sub);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    c_d         = c_q;
    last_d      = last_q;
    sat_d       = sat_q;

    if (in_xfer) begin
      if (state_q == S_IDLE) mode_d = mode;
      if (at_last) begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        state_d = S_RUN;
      end
      out_valid_d = 1'b1;
      c_d         = lane_res;
      last_d      = at_last;
      sat_d       = |lane_sat;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    done_d = out_valid_q & out_ready & last_q;
    // Stays high until the cycle after the final beat leaves, including back-to-back matrices.
    busy_d = (state_d == S_RUN) | out_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      last_q      <= 1'b0;
      sat_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      last_q      <= last_d;
      sat_q       <= sat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign c_out     = c_q;
  assign out_last  = last_q;
  assign sat_flag  = sat_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_matrix_add_stream.sv
// tb/tb_matrix_add_stream.sv - directed self-checking bench for matrix_add_stream
module tb_matrix_add_stream;

  localparam int BEATS = 18;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] c_out;
  logic        out_last;
  logic        sat_flag;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [63:0] av [BEATS];
  logic [63:0] bv [BEATS];
  logic [63:0] cv [BEATS];
  logic        sv [BEATS];

  matrix_add_stream dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .c_out(c_out),
    .out_last(out_last), .sat_flag(sat_flag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic fill_const(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic s);
    for (int i = 0; i < BEATS; i++) begin
      av[i] = {a, a};
      bv[i] = {b, b};
      cv[i] = {c, c};
      sv[i] = s;
    end
  endtask

  // Streams one matrix in and checks every beat out, in order, plus out_last, done and busy.
  task automatic run_matrix(input logic m, input int stall_pct, input bit tog);
    int          ib, ob, cyc;
    bit          done_exp, stalled;
    logic [63:0] held;
    ib = 0; ob = 0; cyc = 0; done_exp = 0; stalled = 0; held = '0;
    while ((ob < BEATS || done_exp) && cyc < 400) begin
      if (done_exp) begin
        chk("done", done, 1);
        chk("busy_after", busy, 0);
        done_exp = 0;
      end
      if (stalled) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", c_out, held);
      end
      out_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
      in_valid  = (ib < BEATS);
      a_in      = (ib < BEATS) ? av[ib] : '0;
      b_in      = (ib < BEATS) ? bv[ib] : '0;
      mode      = (ib != 0 && tog) ? ~m : m;
      #1;
      if (out_valid && out_ready) begin
        chk($sformatf("data%0d", ob), c_out, cv[ob]);
        chk($sformatf("sat%0d", ob), sat_flag, sv[ob]);
        chk($sformatf("last%0d", ob), out_last, (ob == BEATS - 1));
        if (ob == 5) chk("busy_mid", busy, 1);
        if (ob == BEATS - 1) done_exp = 1;
        ob++;
      end
      if (in_valid && in_ready) ib++;
      stalled = out_valid && !out_ready;
      held    = c_out;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (cyc >= 400) chk("timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_c", c_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    fill_const(32'h00056fc2, 32'h0006487e, 32'h000bb840, 1'b0);
    run_matrix(1'b0, 0, 0);

    fill_const(32'h00056fc2, 32'h0006487e, 32'h8000d8bc, 1'b0);
    run_matrix(1'b1, 0, 0);
    fill_const(32'h0006487e, 32'h00056fc2, 32'h0000d8bc, 1'b0);
    run_matrix(1'b1, 0, 0);

    for (int i = 0; i < BEATS; i++) begin
      case (i % 3)
        0: begin
          av[i] = {32'hffffffff, 32'h7fffffff}; bv[i] = {32'h80000001, 32'h00000001};
          cv[i] = {32'hffffffff, 32'h7fffffff}; sv[i] = 1'b1;
        end
        1: begin
          av[i] = {32'h80000000, 32'h80000005}; bv[i] = {32'h80000000, 32'h00000005};
          cv[i] = 64'h0; sv[i] = 1'b0;
        end
        default: begin
          av[i] = {32'h80000005, 32'h7fffffff}; bv[i] = {32'h00000005, 32'h00000001};
          cv[i] = {32'h00000000, 32'h7fffffff}; sv[i] = 1'b1;
        end
      endcase
    end
    run_matrix(1'b0, 0, 0);

    for (int i = 0; i < BEATS; i++) begin
      av[i] = {32'(i * 16 + 1), 32'(i * 16)};
      bv[i] = {32'h00000100, 32'h00000100};
      cv[i] = {32'(i * 16 + 1 + 256), 32'(i * 16 + 256)};
      sv[i] = 1'b0;
    end
    run_matrix(1'b0, 40, 1);

    fill_const(32'h00056fc2, 32'h0006487e, 32'h000bb840, 1'b0);
    out_ready = 1'b1;
    mode      = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; a_in = av[i]; b_in = bv[i];
      @(posedge clk); #1;
      mode = 1'b1;
    end
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_valid", out_valid, 1);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 1);
    rst = 1'b0;
    fill_const(32'h00056fc2, 32'h0006487e, 32'h8000d8bc, 1'b0);
    run_matrix(1'b1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
